// File: rtl/tx_channel.sv
// Transmit end of one VALID/READY channel: small FIFO from the upper module feeding the bus.
// Latency: a push into an empty FIFO shows as VALID/xDATA from that same edge (1 cycle); 1 word/cycle streaming.
// Backpressure: holds VALID/xDATA until READY; tx_full stops pushes, and a push while full is dropped.
//
// Ports:
//   ACLK, ARESETn          bus clock, async active-low reset
//   VALID, READY, xDATA    bus side; xDATA is the FIFO head while VALID=1, else 0
//   tx_data, tx_push       upper-module write port
//   tx_full, tx_empty      FIFO status (tx_full also high during the post-reset cycle)
//   tx_count               occupied entries, 0..DEPTH
//   tx_sent                registered one-cycle pulse after each handshake
module tx_channel #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  output logic                     VALID,
  input  logic                     READY,
  output logic [WIDTH-1:0]         xDATA,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_push,
  output logic                     tx_full,
  output logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     tx_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             sent_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_ok;
  logic pop;

  // tx_full reflects the count before this edge's pop, so a push at full is
  // dropped even when a pop happens on the same edge.
  assign push_ok = tx_push && !tx_full;
  assign pop     = VALID && READY;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_RST;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sent_q   <= pop;
    end
  end

  // Storage is not reset; contents are only observable behind a valid count.
  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_RST:  state_d = ST_IDLE;
      ST_IDLE: if (push_ok) state_d = ST_SEND;
      ST_SEND: if (pop && !push_ok && count_q == (AW+1)'(1)) state_d = ST_IDLE;
      default: state_d = ST_RST;
    endcase
  end

  // Outputs: all decoded from registered state, never from READY.
  always_comb begin
    VALID    = 1'b0;
    tx_full  = 1'b0;
    tx_empty = 1'b0;
    xDATA    = '0;
    VALID    = (state_q == ST_SEND);
    tx_full  = (state_q == ST_RST) || (count_q == FULL_CNT);
    tx_empty = (count_q == '0);
    if (VALID) xDATA = mem_q[rd_ptr_q];
  end

  assign tx_count = count_q;
  assign tx_sent  = sent_q;

endmodule

// File: tb/tb_tx_channel.sv
module tb_tx_channel;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 1 + WIDTH + 1 + 1 + CW + 1;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             VALID;
  logic             READY = 1'b1;
  logic [WIDTH-1:0] xDATA;
  logic [WIDTH-1:0] tx_data = 8'h33;
  logic             tx_push = 1'b1;
  logic             tx_full;
  logic             tx_empty;
  logic [CW-1:0]    tx_count;
  logic             tx_sent;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending words plus the post-reset blocking cycle.
  logic [WIDTH-1:0] q[$];
  bit               m_rst  = 1'b1;
  bit               m_sent = 1'b0;

  tx_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .VALID    (VALID),
    .READY    (READY),
    .xDATA    (xDATA),
    .tx_data  (tx_data),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_count (tx_count),
    .tx_sent  (tx_sent)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [VW-1:0] exp_vec();
    logic             v;
    logic [WIDTH-1:0] d;
    v = (q.size() > 0);
    d = v ? q[0] : '0;
    return {v, d, (q.size() == DEPTH) || m_rst, q.size() == 0, CW'(q.size()), m_sent};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {VALID, xDATA, tx_full, tx_empty, tx_count, tx_sent};
  endfunction

  // Advance one edge; the model follows the bus rules with the inputs driven before the edge.
  task automatic step();
    bit pop, push_ok;
    logic [WIDTH-1:0] d;
    pop     = (q.size() > 0) && READY;
    push_ok = tx_push && !((q.size() == DEPTH) || m_rst);
    d       = tx_data;
    @(posedge ACLK);
    if (ARESETn) begin
      if (pop) q.delete(0);
      if (push_ok) q.push_back(d);
      m_sent = pop;
      m_rst  = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_rst  = 1'b1;
    m_sent = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (VALID !== 1'b0 || xDATA !== 8'h00 || tx_full !== 1'b1 || tx_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: VALID=%b xDATA=%h full=%b count=%0d expected 0,00,1,0",
               VALID, xDATA, tx_full, tx_count);
    end
    ARESETn = 1'b1;
    step();
    checks++;
    if (tx_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_push_dropped: count=%0d expected 0", tx_count);
    end
    step();
    checks++;
    if (tx_count !== 3'd1 || VALID !== 1'b1 || xDATA !== 8'h33) begin
      errors++;
      $display("FAIL reset_second_push: count=%0d VALID=%b xDATA=%h expected 1,1,33",
               tx_count, VALID, xDATA);
    end
    tx_push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_drain: got %h expected %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    READY = 1'b0; tx_data = 8'hA5; tx_push = 1'b1;
    step();
    tx_push = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (VALID !== 1'b1 || xDATA !== 8'hA5 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_hold cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      step();
    end
    READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += tx_sent;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_pop cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || VALID !== 1'b0 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_sent: pulses=%0d VALID=%b empty=%b expected 1,0,1", pulses, VALID, tx_empty);
    end
  endtask

  task automatic test_fill();
    READY = 1'b0; tx_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tx_data = 8'(i);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill_push%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (tx_full !== 1'b1 || tx_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d expected 1,4", tx_full, tx_count);
    end
    tx_push = 1'b0; READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (VALID !== 1'b1 || xDATA !== 8'(i + 1)) begin
        errors++;
        $display("FAIL fill_order%0d: VALID=%b xDATA=%h expected 1,%h", i, VALID, xDATA, 8'(i + 1));
      end
      step();
    end
    checks++;
    if (VALID !== 1'b0 || xDATA !== 8'h00 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL fill_end: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stream();
    READY = 1'b1; tx_push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 8'h10 + 8'(i);
      step();
      checks++;
      if (VALID !== 1'b1 || xDATA !== 8'h10 + 8'(i) || tx_count > 3'd1 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stream%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    tx_push = 1'b0;
    step();
    checks++;
    if (VALID !== 1'b0 || tx_sent !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stream_end: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    READY = 1'b0; tx_push = 1'b1; tx_data = 8'h40;
    step();
    READY = 1'b1; tx_data = 8'h41;
    step();
    checks++;
    if (VALID !== 1'b1 || tx_count !== 3'd1 || xDATA !== 8'h41) begin
      errors++;
      $display("FAIL simul_count1: VALID=%b count=%0d xDATA=%h expected 1,1,41", VALID, tx_count, xDATA);
    end
    READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h42 + 8'(i);
      step();
    end
    READY = 1'b1; tx_data = 8'h55;
    step();
    checks++;
    if (tx_count !== 3'(DEPTH - 1) || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_full_drop: got %h expected %h", obs_vec(), exp_vec());
    end
    tx_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xDATA === 8'h55 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_drain%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    READY = 1'b0; tx_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h71 + 8'(i);
      step();
    end
    tx_push = 1'b0;
    step();
    ARESETn = 1'b0;
    #2;
    model_reset();
    checks++;
    if (VALID !== 1'b0 || xDATA !== 8'h00 || tx_full !== 1'b1 || tx_count !== 3'd0) begin
      errors++;
      $display("FAIL midreset_async: VALID=%b xDATA=%h full=%b count=%0d expected 0,00,1,0",
               VALID, xDATA, tx_full, tx_count);
    end
    #2;
    ARESETn = 1'b1;
    READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (VALID !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_after%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    tx_push = 1'b1; tx_data = 8'h99; READY = 1'b0;
    step();
    tx_push = 1'b0;
    checks++;
    if (xDATA !== 8'h99 || tx_count !== 3'd1) begin
      errors++;
      $display("FAIL midreset_newword: xDATA=%h count=%0d expected 99,1", xDATA, tx_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tx_push = 1'($urandom_range(0, 99) < 60);
      READY   = 1'($urandom_range(0, 99) < 50);
      tx_data = 8'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    tx_push = 1'b0; READY = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_channel.md
# tx_channel

Transmitting end of a single VALID/READY channel: it accepts words from the upper module into a small FIFO and presents them on the bus as xDATA with VALID, popping one word per completed handshake. It is the transmit-side companion of the channel receiver. It sits between the master's or slave's datapath and one bus channel (AW/W/AR/R/B), and is reused per channel.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- ACLK  in  1  bus clock; all state updates on rising edge
- ARESETn  in  1  reset; asynchronous, active-low
- VALID  out  1  bus VALID, driven from a register
- READY  in  1  bus READY from receiver
- xDATA  out  WIDTH  bus data = FIFO head while VALID=1, 0 while VALID=0
- tx_data  in  WIDTH  word from upper module
- tx_push  in  1  write tx_data into FIFO this edge (ignored when tx_full=1)
- tx_full  out  1  count==DEPTH, or state==RST
- tx_empty  out  1  count==0
- tx_count  out  $clog2(DEPTH)+1  occupied entries
- tx_sent  out  1  registered one-cycle pulse after each handshake

## Operation
- Storage: DEPTH×WIDTH array, rd_ptr/wr_ptr of $clog2(DEPTH) bits with natural wrap, separate count register (0..DEPTH).
- push_ok = tx_push && !tx_full; pop = VALID && READY.
- On push_ok: mem[wr_ptr]<=tx_data, wr_ptr++. On pop: rd_ptr++. count += push_ok − pop (both in one edge: count unchanged).
- Push while full is dropped silently, even if a pop happens on the same edge; tx_full is computed from the current count, before that edge's pop.
- States:
  - RST: entered on reset, held for one cycle. VALID=0 and tx_full=1, so no push is accepted. Always goes to IDLE.
  - IDLE: VALID=0. Goes to SEND when push_ok.
  - SEND: VALID=1. On pop with count==1 and no push_ok, goes to IDLE. Otherwise stays in SEND.
- VALID never depends combinationally on READY. Once VALID=1, VALID and xDATA hold until the pop edge.
  - This holds because rd_ptr only moves on pop, and writes never target the head slot while count>0 and count<DEPTH, or when count is full, since full blocks pushes.
- xDATA = VALID ? mem[rd_ptr] : 0 (combinational mux from registered state and pointers).
- tx_sent <= pop.
- Reset, including assertion mid-transfer: state=RST, VALID=0, xDATA=0, pointers=0, count=0, tx_sent=0, tx_empty=1, tx_full=1. FIFO contents are discarded; mem need not be reset.

## Timing
- Latency from a push into an empty FIFO to VALID: 1 cycle. If push_ok occurs at edge N, VALID=1 and xDATA=that word from edge N.
- Throughput: one word per cycle with READY held high and the FIFO non-empty. Each pop edge advances xDATA to the next word with no VALID bubble.
- When the last word pops at edge N with no simultaneous push, VALID=0 from edge N.
- When the last word pops and a push lands at the same edge N, VALID stays 1 and xDATA = the pushed word from edge N.
- READY may be high before VALID. No transfer occurs until VALID=1; READY has no effect in RST or IDLE.
- tx_sent is high for the single cycle following each pop edge.
- After ARESETn deasserts, the first push can be accepted at the second rising edge: the first edge leaves RST, the second edge is in IDLE.

## Test plan
- Reset: hold ARESETn=0 with tx_push=1 and READY=1 → VALID=0, xDATA=0, tx_count=0, tx_full=1. After release, the push at the first edge is dropped, the push at the second edge is accepted, and tx_count=1.
- Single word: push 8'hA5 with READY=0 → VALID=1, xDATA=A5 next cycle, held stable for 5 cycles. Raise READY → one pop, tx_sent pulses once, VALID=0, tx_empty=1.
- Fill/overflow: push 8'h01..8'h05 with READY=0, DEPTH=4 → tx_full=1 after 4 pushes, 8'h05 dropped. Then READY=1 → xDATA sequence 01,02,03,04 on consecutive cycles, then VALID=0.
- Streaming: READY=1 constantly, push 16 consecutive words 8'h10..8'h1F → VALID stays high continuously from the cycle after the first push. Output order matches input, tx_count stays ≤1, and pointers wrap correctly.
- Simultaneous push/pop at count==1 → VALID stays 1, tx_count stays 1, and xDATA switches to the new word. Also push at full with a same-edge pop → push dropped, tx_count=DEPTH−1.
- Mid-transfer reset: with 3 words queued, VALID=1 and READY=0, pulse ARESETn low between edges → VALID and xDATA drop to 0 immediately. After release tx_count=0, and the old words never appear.
